// File: rtl/pmem_arbiter.sv
// Physical-memory port arbiter: shares one line-wide memory port between the
// read-only I-cache and the read/write-back D-cache. One requester is granted
// at a time; the granted command, address and write line are registered toward
// memory and held until mem_resp, which is routed back to the granted cache only.
module pmem_arbiter #(
    parameter int s_line  = 256,
    parameter bit RR_MODE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [31:0]       i_pmem_address,
    output logic              i_pmem_resp,
    output logic [s_line-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [31:0]       d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [s_line-1:0] d_pmem_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [s_line-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t            state;
    state_t            state_next;
    grant_t            last_grant;
    grant_t            last_grant_next;

    logic              mem_read_next;
    logic              mem_write_next;
    logic [31:0]       mem_address_next;
    logic [s_line-1:0] mem_wdata_next;

    logic              i_req;
    logic              d_req;
    logic              grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Read data is a plain fan-out; each cache qualifies it with its own resp.
    assign i_pmem_rdata = mem_rdata;
    assign d_pmem_rdata = mem_rdata;

    // Arbitration decision used in IDLE: on a tie, round-robin hands the port to
    // whoever was not served last, fixed priority always favours the D-cache.
    always_comb begin
        grant_d = 1'b0;
        if (i_req && d_req) begin
            if (RR_MODE) begin
                grant_d = (last_grant == GRANT_I);
            end else begin
                grant_d = 1'b1;
            end
        end else begin
            grant_d = d_req;
        end
    end

    // Next-state, next memory command and combinational resp routing.
    always_comb begin
        state_next       = state;
        last_grant_next  = last_grant;
        mem_read_next    = mem_read;
        mem_write_next   = mem_write;
        mem_address_next = mem_address;
        mem_wdata_next   = mem_wdata;
        i_pmem_resp      = 1'b0;
        d_pmem_resp      = 1'b0;

        case (state)
            IDLE: begin
                // A stray mem_resp here is deliberately ignored.
                mem_read_next  = 1'b0;
                mem_write_next = 1'b0;
                if (grant_d) begin
                    state_next       = SERVE_D;
                    mem_read_next    = d_pmem_read;
                    mem_write_next   = d_pmem_write;
                    mem_address_next = d_pmem_address;
                    mem_wdata_next   = d_pmem_wdata;
                end else if (i_req) begin
                    state_next       = SERVE_I;
                    mem_read_next    = 1'b1;
                    mem_address_next = i_pmem_address;
                end
            end

            SERVE_I: begin
                if (mem_resp) begin
                    i_pmem_resp     = 1'b1;
                    mem_read_next   = 1'b0;
                    mem_write_next  = 1'b0;
                    last_grant_next = GRANT_I;
                    state_next      = IDLE;
                end
            end

            SERVE_D: begin
                if (mem_resp) begin
                    d_pmem_resp     = 1'b1;
                    mem_read_next   = 1'b0;
                    mem_write_next  = 1'b0;
                    last_grant_next = GRANT_D;
                    state_next      = IDLE;
                end
            end

            default: begin
                mem_read_next  = 1'b0;
                mem_write_next = 1'b0;
                state_next     = IDLE;
            end
        endcase
    end

    // State, grant history and registered memory interface.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= GRANT_D;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_next;
            last_grant  <= last_grant_next;
            mem_read    <= mem_read_next;
            mem_write   <= mem_write_next;
            mem_address <= mem_address_next;
            mem_wdata   <= mem_wdata_next;
        end
    end

    // A simultaneous D-cache read and write-back is a protocol violation by the cache.
    illegal_d_read_write: assert property (
        @(posedge clk) disable iff (!rst) !(d_pmem_read && d_pmem_write)
    );

endmodule
